// File: rtl/kamikaze_execute_if.sv
// Decode-to-execute request and execute-to-writeback result bundle.
// The execute stage uses the slave modport; decode/writeback use the master modport.
interface kamikaze_execute_if;
    logic        decode_valid_i;
    logic [2:0]  alu_func_i;
    logic        alu_alt_i;
    logic [31:0] alu_op1_i;
    logic [31:0] alu_op2_i;
    logic [4:0]  rf_rd_i;
    logic        rf_rd_we_i;
    logic [31:0] pc_i;
    logic [31:0] pc_next_i;

    logic        ex_valid_o;
    logic        ex_we_o;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic        ex_busy_o;

    modport master (
        output decode_valid_i, alu_func_i, alu_alt_i, alu_op1_i, alu_op2_i,
               rf_rd_i, rf_rd_we_i, pc_i, pc_next_i,
        input  ex_valid_o, ex_we_o, ex_wd_o, ex_wdata_o, pc_o, pc_next_o, ex_busy_o
    );

    modport slave (
        input  decode_valid_i, alu_func_i, alu_alt_i, alu_op1_i, alu_op2_i,
               rf_rd_i, rf_rd_we_i, pc_i, pc_next_i,
        output ex_valid_o, ex_we_o, ex_wd_o, ex_wdata_o, pc_o, pc_next_o, ex_busy_o
    );
endinterface

// File: rtl/kamikaze_execute.sv
// RV32I integer execute stage: single-cycle ALU plus an optional 1-bit-per-cycle shifter.
// All writeback/forwarding outputs are registered.
module kamikaze_execute #(
    parameter bit SHIFT_SERIAL = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    kamikaze_execute_if.slave  ex_if
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  func_q, func_d;
    logic        alt_q, alt_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic [31:0] pc_hold_q, pc_hold_d;
    logic [31:0] pcn_hold_q, pcn_hold_d;

    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [4:0]  wd_q, wd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        busy_q, busy_d;

    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic [31:0] sra_result;
    logic        is_shift;
    logic        start_serial;
    logic [31:0] acc_step;

    assign shamt    = ex_if.alu_op2_i[4:0];
    assign is_shift = (ex_if.alu_func_i == 3'b001) || (ex_if.alu_func_i == 3'b101);
    assign start_serial = SHIFT_SERIAL && is_shift && (shamt != 5'd0);

    always_comb begin
        sra_result = $signed(ex_if.alu_op1_i) >>> shamt;
        alu_result = '0;
        case (ex_if.alu_func_i)
            3'b000: alu_result = ex_if.alu_alt_i ? ex_if.alu_op1_i - ex_if.alu_op2_i
                                                 : ex_if.alu_op1_i + ex_if.alu_op2_i;
            3'b001: alu_result = ex_if.alu_op1_i << shamt;
            3'b010: alu_result = {31'd0, $signed(ex_if.alu_op1_i) < $signed(ex_if.alu_op2_i)};
            3'b011: alu_result = {31'd0, ex_if.alu_op1_i < ex_if.alu_op2_i};
            3'b100: alu_result = ex_if.alu_op1_i ^ ex_if.alu_op2_i;
            3'b101: alu_result = ex_if.alu_alt_i ? sra_result : ex_if.alu_op1_i >> shamt;
            3'b110: alu_result = ex_if.alu_op1_i | ex_if.alu_op2_i;
            default: alu_result = ex_if.alu_op1_i & ex_if.alu_op2_i;
        endcase
    end

    // One bit per cycle; SRA replicates the sign, SLL/SRL fill with zero.
    always_comb begin
        if (func_q == 3'b001) begin
            acc_step = {acc_q[30:0], 1'b0};
        end else begin
            acc_step = {alt_q & acc_q[31], acc_q[31:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        func_d     = func_q;
        alt_d      = alt_q;
        rd_d       = rd_q;
        rd_we_d    = rd_we_q;
        pc_hold_d  = pc_hold_q;
        pcn_hold_d = pcn_hold_q;
        valid_d    = 1'b0;
        we_d       = 1'b0;
        wd_d       = wd_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        pc_next_d  = pc_next_q;
        busy_d     = busy_q;

        case (state_q)
            StIdle: begin
                if (ex_if.decode_valid_i) begin
                    if (start_serial) begin
                        acc_d      = ex_if.alu_op1_i;
                        cnt_d      = shamt;
                        func_d     = ex_if.alu_func_i;
                        alt_d      = ex_if.alu_alt_i;
                        rd_d       = ex_if.rf_rd_i;
                        rd_we_d    = ex_if.rf_rd_we_i;
                        pc_hold_d  = ex_if.pc_i;
                        pcn_hold_d = ex_if.pc_next_i;
                        state_d    = StShift;
                        busy_d     = 1'b1;
                    end else begin
                        valid_d   = 1'b1;
                        we_d      = ex_if.rf_rd_we_i && (ex_if.rf_rd_i != 5'd0);
                        wd_d      = ex_if.rf_rd_i;
                        wdata_d   = alu_result;
                        pc_d      = ex_if.pc_i;
                        pc_next_d = ex_if.pc_next_i;
                    end
                end
            end
            StShift: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    valid_d   = 1'b1;
                    we_d      = rd_we_q && (rd_q != 5'd0);
                    wd_d      = rd_q;
                    wdata_d   = acc_step;
                    pc_d      = pc_hold_q;
                    pc_next_d = pcn_hold_q;
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            func_q     <= '0;
            alt_q      <= 1'b0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            pc_hold_q  <= '0;
            pcn_hold_q <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            pc_next_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            func_q     <= func_d;
            alt_q      <= alt_d;
            rd_q       <= rd_d;
            rd_we_q    <= rd_we_d;
            pc_hold_q  <= pc_hold_d;
            pcn_hold_q <= pcn_hold_d;
            valid_q    <= valid_d;
            we_q       <= we_d;
            wd_q       <= wd_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            pc_next_q  <= pc_next_d;
            busy_q     <= busy_d;
        end
    end

    assign ex_if.ex_valid_o = valid_q;
    assign ex_if.ex_we_o    = we_q;
    assign ex_if.ex_wd_o    = wd_q;
    assign ex_if.ex_wdata_o = wdata_q;
    assign ex_if.pc_o       = pc_q;
    assign ex_if.pc_next_o  = pc_next_q;
    assign ex_if.ex_busy_o  = busy_q;

endmodule

// File: tb/tb_kamikaze_execute.sv
// Randomized self-checking bench for kamikaze_execute (serial shifter) against a
// behavioural ALU/timing model.
module tb_kamikaze_execute;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [4:0]  held_wd;
    logic [31:0] held_wdata;
    logic [31:0] held_pc;
    logic [31:0] held_pcn;

    kamikaze_execute_if bus ();

    kamikaze_execute #(.SHIFT_SERIAL(1'b1)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .ex_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spec-level ALU: shifts by the low 5 bits of b, SRA built as SRL plus sign fill.
    function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (f)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: begin
                if (a[31] != b[31]) r = a[31] ? 32'd1 : 32'd0;
                else                r = (a < b) ? 32'd1 : 32'd0;
            end
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (alt && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic drive_idle();
        bus.decode_valid_i = 1'b0;
    endtask

    task automatic scramble();
        bus.decode_valid_i = 1'($urandom);
        bus.alu_func_i     = 3'($urandom);
        bus.alu_alt_i      = 1'($urandom);
        bus.alu_op1_i      = $urandom;
        bus.alu_op2_i      = $urandom;
        bus.rf_rd_i        = 5'($urandom);
        bus.rf_rd_we_i     = 1'($urandom);
        bus.pc_i           = $urandom;
        bus.pc_next_i      = $urandom;
    endtask

    task automatic issue(input logic [2:0] f, input logic alt, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic we,
                         input logic [31:0] pc, input logic [31:0] pcn, input bit mess);
        logic [31:0] exp;
        int          n_edges;
        @(negedge clk);
        bus.decode_valid_i = 1'b1;
        bus.alu_func_i     = f;
        bus.alu_alt_i      = alt;
        bus.alu_op1_i      = a;
        bus.alu_op2_i      = b;
        bus.rf_rd_i        = rd;
        bus.rf_rd_we_i     = we;
        bus.pc_i           = pc;
        bus.pc_next_i      = pcn;
        exp     = ref_alu(f, alt, a, b);
        n_edges = ((f == 3'd1 || f == 3'd5) && (b % 32) != 0) ? int'(b % 32) : 0;
        @(posedge clk);
        #1;
        drive_idle();
        for (int k = 0; k < n_edges; k++) begin
            check("busy_during_shift", 32'(bus.ex_busy_o), 32'd1);
            check("valid_during_shift", 32'(bus.ex_valid_o), 32'd0);
            if (mess) scramble();
            @(posedge clk);
            #1;
        end
        drive_idle();
        check("valid", 32'(bus.ex_valid_o), 32'd1);
        check("we", 32'(bus.ex_we_o), 32'(we && rd != 5'd0));
        check("wd", 32'(bus.ex_wd_o), 32'(rd));
        check("wdata", bus.ex_wdata_o, exp);
        check("pc", bus.pc_o, pc);
        check("pc_next", bus.pc_next_o, pcn);
        check("busy_after", 32'(bus.ex_busy_o), 32'd0);
        held_wd    = rd;
        held_wdata = exp;
        held_pc    = pc;
        held_pcn   = pcn;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("idle_valid", 32'(bus.ex_valid_o), 32'd0);
        check("idle_we", 32'(bus.ex_we_o), 32'd0);
        check("idle_busy", 32'(bus.ex_busy_o), 32'd0);
        check("hold_wd", 32'(bus.ex_wd_o), 32'(held_wd));
        check("hold_wdata", bus.ex_wdata_o, held_wdata);
        check("hold_pc", bus.pc_o, held_pc);
        check("hold_pc_next", bus.pc_next_o, held_pcn);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.ex_valid_o), 32'd0);
        check({tag, "_we"}, 32'(bus.ex_we_o), 32'd0);
        check({tag, "_wd"}, 32'(bus.ex_wd_o), 32'd0);
        check({tag, "_wdata"}, bus.ex_wdata_o, 32'd0);
        check({tag, "_pc"}, bus.pc_o, 32'd0);
        check({tag, "_pc_next"}, bus.pc_next_o, 32'd0);
        check({tag, "_busy"}, 32'(bus.ex_busy_o), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0]  f;
        logic [31:0] b;
        n_checks   = 0;
        n_pass     = 0;
        held_wd    = '0;
        held_wdata = '0;
        held_pc    = '0;
        held_pcn   = '0;
        scramble();
        drive_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed cases from the test plan.
        issue(3'd0, 1'b0, 32'd5, 32'hFFFF_FFFD, 5'd3, 1'b1, 32'h100, 32'h104, 1'b0);
        issue(3'd0, 1'b1, 32'd0, 32'd1, 5'd4, 1'b1, 32'h104, 32'h108, 1'b0);
        issue(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'h108, 32'h10C, 1'b0);
        issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'h10C, 32'h110, 1'b0);
        issue(3'd5, 1'b1, 32'h8000_0000, 32'd4, 5'd7, 1'b1, 32'h110, 32'h114, 1'b1);
        issue(3'd5, 1'b0, 32'h8000_0000, 32'd4, 5'd8, 1'b1, 32'h114, 32'h118, 1'b1);
        issue(3'd1, 1'b0, 32'h1234_5678, 32'd32, 5'd9, 1'b1, 32'h118, 32'h11C, 1'b0);
        issue(3'd0, 1'b0, 32'd7, 32'd8, 5'd0, 1'b1, 32'h11C, 32'h120, 1'b0);
        idle_cycle();
        issue(3'd1, 1'b0, 32'h0000_0001, 32'd31, 5'd10, 1'b1, 32'h120, 32'h124, 1'b1);
        idle_cycle();

        // Reset while an SLL by 20 is in flight.
        @(negedge clk);
        bus.decode_valid_i = 1'b1;
        bus.alu_func_i     = 3'd1;
        bus.alu_alt_i      = 1'b0;
        bus.alu_op1_i      = 32'h0000_00FF;
        bus.alu_op2_i      = 32'd20;
        bus.rf_rd_i        = 5'd11;
        bus.rf_rd_we_i     = 1'b1;
        bus.pc_i           = 32'h200;
        bus.pc_next_i      = 32'h204;
        @(posedge clk);
        #1;
        drive_idle();
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.ex_busy_o), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.ex_valid_o || bus.ex_we_o || bus.ex_busy_o) pulses++;
        end
        check("no_pulse_after_abort", 32'(pulses), 32'd0);
        held_wd    = '0;
        held_wdata = '0;
        held_pc    = '0;
        held_pcn   = '0;
        idle_cycle();
        issue(3'd0, 1'b0, 32'd40, 32'd2, 5'd12, 1'b1, 32'h208, 32'h20C, 1'b0);

        // Randomized instruction stream with mid-shift input noise.
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom);
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFFFF_FFE0;
            issue(f, 1'($urandom), $urandom, b, 5'($urandom), 1'($urandom),
                  $urandom, $urandom, 1'b1);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
